// File: rtl/reduce_pipe_if.sv
// rtl/reduce_pipe_if.sv - handshake bundle for the pipelined reduction unit
//
// Purpose: groups the input beat channel and the result channel of reduce_pipe.
//   in_valid/in_ready/in_data/in_op    : beat to reduce and the op to apply
//   out_valid/out_ready/out_result/out_op : reduced bit and the op that produced it
//   out_count                          : completed-result counter (REDUCE_STATS_EN only)
// Modports: slave = the reduction unit, master = the producer/consumer side.
// Optional feature macro: REDUCE_STATS_EN.

interface reduce_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic             out_result;
    logic [1:0]       out_op;
`ifdef REDUCE_STATS_EN
    logic [15:0]      out_count;
`endif

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op
`ifdef REDUCE_STATS_EN
        , output out_count
`endif
    );

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op
`ifdef REDUCE_STATS_EN
        , input out_count
`endif
    );
endinterface

// File: rtl/reduce_pipe.sv
// rtl/reduce_pipe.sv - pipelined FANIN-ary reduction (AND/OR/XOR/XNOR) with valid/ready
//
// Purpose: reduces WIDTH input bits to one bit through a registered tree whose
//   nodes each combine FANIN partials. Latency equals STAGES = ceil(log_FANIN(WIDTH)).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous assert, active-low reset
//   bus   : reduce_pipe_if.slave (in_* beat channel, out_* result channel,
//           out_count only when REDUCE_STATS_EN is defined)
// Optional feature macro: REDUCE_STATS_EN (saturating 16-bit output-transfer counter).

module reduce_pipe #(
    parameter int WIDTH = 16,
    parameter int FANIN = 4
) (
    input  logic         clock,
    input  logic         reset,
    reduce_pipe_if.slave bus
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XNOR = 2'b11;

    // Number of live partials entering stage k (k=0 is the raw input word).
    function automatic int level_n(input int k);
        int n;
        n = WIDTH;
        for (int i = 0; i < k; i++) begin
            n = (n + FANIN - 1) / FANIN;
        end
        return n;
    endfunction

    function automatic int calc_stages();
        int n;
        int s;
        n = WIDTH;
        s = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (n > 1) begin
                n = (n + FANIN - 1) / FANIN;
                s = s + 1;
            end
        end
        if (s < 1) begin
            s = 1;
        end
        return s;
    endfunction

    localparam int STAGES = calc_stages();

    // One tree level: output bit j combines inputs j*FANIN .. j*FANIN+FANIN-1.
    // Leaves at or beyond n are left at the accumulator's start value, which
    // is the op identity, so a ragged last group needs no special handling.
    // XNOR is reduced as XOR here; inversion happens once at the last stage.
    function automatic logic [WIDTH-1:0] reduce_level(
        input logic [WIDTH-1:0] v,
        input int               n,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] v_sh;
        logic             acc;
        int               idx;
        r = '0;
        for (int j = 0; j < WIDTH; j++) begin
            acc = (op == OP_AND);
            for (int i = 0; i < FANIN; i++) begin
                idx = j * FANIN + i;
                if (idx < n) begin
                    v_sh = v >> idx;
                    case (op)
                        OP_AND:  acc = acc & v_sh[0];
                        OP_OR:   acc = acc | v_sh[0];
                        default: acc = acc ^ v_sh[0];
                    endcase
                end
            end
            // Shift in from the top so the first group lands in bit 0.
            r = {acc, r[WIDTH-1:1]};
        end
        return r;
    endfunction

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [1:0]        op_q   [STAGES];
    logic [1:0]        op_d   [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic              adv;

    always_comb begin
        // Whole pipe moves together: it only stalls when a result is waiting
        // and the consumer refuses it. No bubble collapsing.
        adv = !vld_q[STAGES-1] || bus.out_ready;

        data_d[0] = reduce_level(bus.in_data, WIDTH, bus.in_op);
        op_d[0]   = bus.in_op;
        vld_d     = '0;
        vld_d[0]  = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            data_d[k] = reduce_level(data_q[k-1], level_n(k), op_q[k-1]);
            op_d[k]   = op_q[k-1];
            vld_d[k]  = vld_q[k-1];
        end

        if (op_d[STAGES-1] == OP_XNOR) begin
            data_d[STAGES-1][0] = ~data_d[STAGES-1][0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= OP_AND;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = vld_q[STAGES-1];
    assign bus.out_result = data_q[STAGES-1][0];
    assign bus.out_op     = op_q[STAGES-1];

`ifdef REDUCE_STATS_EN
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (vld_q[STAGES-1] && bus.out_ready && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_reduce_pipe.sv
// tb/tb_reduce_pipe.sv - scoreboard bench for reduce_pipe (16/4 and 5/4 instances)

module tb_reduce_pipe;

    localparam int STAGES16 = 2;
    localparam int STAGES5  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    reduce_pipe_if #(.WIDTH(16)) b16 ();
    reduce_pipe_if #(.WIDTH(5))  b5 ();

    reduce_pipe #(.WIDTH(16), .FANIN(4)) u16 (.clock(clock), .reset(reset), .bus(b16));
    reduce_pipe #(.WIDTH(5),  .FANIN(4)) u5  (.clock(clock), .reset(reset), .bus(b5));

    typedef struct {
        logic       res;
        logic [1:0] op;
        int         cyc;
        bit         timed;
    } exp_t;

    exp_t q16[$];
    exp_t q5[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int xfer16   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: the op applied to the w low bits of the beat.
    function automatic logic model(input logic [15:0] d, input int w, input logic [1:0] op);
        logic [15:0] m;
        logic [15:0] x;
        m = 16'((32'h1 << w) - 1);
        x = d & m;
        case (op)
            2'b00:   return &(x | ~m);
            2'b01:   return |x;
            2'b10:   return ^x;
            default: return ~(^x);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push16(input bit timed);
        exp_t e;
        e.res   = model(b16.in_data, 16, b16.in_op);
        e.op    = b16.in_op;
        e.cyc   = cyc;
        e.timed = timed;
        q16.push_back(e);
    endtask

    task automatic push5(input bit timed);
        exp_t e;
        e.res   = model({11'd0, b5.in_data}, 5, b5.in_op);
        e.op    = b5.in_op;
        e.cyc   = cyc;
        e.timed = timed;
        q5.push_back(e);
    endtask

    task automatic send16(input logic [15:0] d, input logic [1:0] op, input bit timed);
        int g;
        @(negedge clock);
        b16.in_valid = 1'b1;
        b16.in_data  = d;
        b16.in_op    = op;
        #1;
        g = 0;
        while (!b16.in_ready && g < 100) begin
            @(negedge clock);
            #1;
            g++;
        end
        chk("send16_accept", b16.in_ready, 1);
        if (b16.in_ready) push16(timed);
    endtask

    task automatic send5(input logic [4:0] d, input logic [1:0] op, input bit timed);
        int g;
        @(negedge clock);
        b5.in_valid = 1'b1;
        b5.in_data  = d;
        b5.in_op    = op;
        #1;
        g = 0;
        while (!b5.in_ready && g < 100) begin
            @(negedge clock);
            #1;
            g++;
        end
        chk("send5_accept", b5.in_ready, 1);
        if (b5.in_ready) push5(timed);
    endtask

    task automatic drain16();
        int g;
        @(negedge clock);
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b1;
        g = 0;
        while (q16.size() != 0 && g < 50) begin
            @(negedge clock);
            #3;
            g++;
        end
        chk("drain16_empty", q16.size(), 0);
    endtask

    task automatic drain5();
        int g;
        @(negedge clock);
        b5.in_valid  = 1'b0;
        b5.out_ready = 1'b1;
        g = 0;
        while (q5.size() != 0 && g < 50) begin
            @(negedge clock);
            #3;
            g++;
        end
        chk("drain5_empty", q5.size(), 0);
    endtask

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return ~(16'h1 << $urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor for the 16-bit instance: pops on each output transfer and
    // checks that a stalled output does not move.
    initial begin
        exp_t e;
        bit   hold;
        logic held_res;
        logic [1:0] held_op;
        hold = 0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold16_result", b16.out_result, held_res);
                    chk("hold16_op", b16.out_op, held_op);
                    chk("hold16_valid", b16.out_valid, 1);
                end
                if (b16.out_valid && b16.out_ready) begin
                    if (q16.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL out16_unexpected: got result %0b with empty scoreboard", b16.out_result);
                    end else begin
                        e = q16.pop_front();
                        chk("result16", b16.out_result, e.res);
                        chk("op16", b16.out_op, e.op);
                        if (e.timed) chk("latency16", cyc - e.cyc, STAGES16);
                        xfer16++;
                    end
                end
                hold     = b16.out_valid && !b16.out_ready;
                held_res = b16.out_result;
                held_op  = b16.out_op;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset && b5.out_valid && b5.out_ready) begin
                if (q5.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out5_unexpected: got result %0b with empty scoreboard", b5.out_result);
                end else begin
                    e = q5.pop_front();
                    chk("result5", b5.out_result, e.res);
                    chk("op5", b5.out_op, e.op);
                    if (e.timed) chk("latency5", cyc - e.cyc, STAGES5);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       held_res;
        logic [1:0] held_op;

        b16.in_valid = 0; b16.in_data = '0; b16.in_op = 2'b00; b16.out_ready = 0;
        b5.in_valid  = 0; b5.in_data  = '0; b5.in_op  = 2'b00; b5.out_ready  = 0;

        // Reset state
        @(negedge clock);
        #1;
        chk("rst_out_valid", b16.out_valid, 0);
        chk("rst_out_result", b16.out_result, 0);
        chk("rst_out_op", b16.out_op, 0);
        chk("rst_in_ready", b16.in_ready, 1);
        chk("rst5_out_valid", b5.out_valid, 0);
`ifdef REDUCE_STATS_EN
        chk("rst_out_count", b16.out_count, 0);
`endif
        @(negedge clock);
        #3 reset = 1'b1;

        // AND all-set then one-clear, timed
        b16.out_ready = 1'b1;
        send16(16'hFFFF, 2'b00, 1);
        send16(16'hFFFE, 2'b00, 1);

        // OR/XOR/XNOR back-to-back, op echo
        send16(16'h0000, 2'b01, 1);
        send16(16'h0100, 2'b01, 1);
        send16(16'h0007, 2'b10, 1);
        send16(16'h0007, 2'b11, 1);
        drain16();

        // Full pipe with consumer stalled
        @(negedge clock);
        b16.out_ready = 1'b0;
        send16(16'h8000, 2'b01, 0);
        send16(16'hFFFF, 2'b00, 0);
        @(negedge clock);
        b16.in_valid = 1'b1;
        b16.in_data  = 16'h1234;
        b16.in_op    = 2'b10;
        #1;
        chk("full_in_ready", b16.in_ready, 0);
        chk("full_out_valid", b16.out_valid, 1);
        held_res = b16.out_result;
        held_op  = b16.out_op;
        @(negedge clock);
        b16.in_data = 16'h0000;
        b16.in_op   = 2'b00;
        #1;
        chk("full_in_ready2", b16.in_ready, 0);
        chk("full_hold_result", b16.out_result, held_res);
        chk("full_hold_op", b16.out_op, held_op);
        @(negedge clock);
        b16.in_data   = 16'h0001;
        b16.in_op     = 2'b11;
        b16.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", b16.in_ready, 1);
        if (b16.in_ready) push16(0);
        drain16();

        // Random traffic, consumer held ready: full rate, fixed latency
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            b16.out_ready = 1'b1;
            b16.in_valid  = ($urandom_range(0, 3) != 0);
            b16.in_data   = rand_word();
            b16.in_op     = 2'($urandom_range(0, 3));
            #1;
            if (b16.in_valid && b16.in_ready) push16(1);
        end
        drain16();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            b16.out_ready = ($urandom_range(0, 2) != 0);
            b16.in_valid  = ($urandom_range(0, 2) != 0);
            b16.in_data   = rand_word();
            b16.in_op     = 2'($urandom_range(0, 3));
            #1;
            if (b16.in_valid && b16.in_ready) push16(0);
        end
        drain16();
`ifdef REDUCE_STATS_EN
        chk("count_after_random", b16.out_count, xfer16);
`endif

        // WIDTH=5 instance: identity padding of the ragged group
        b5.out_ready = 1'b1;
        send5(5'b11111, 2'b00, 1);
        send5(5'b01111, 2'b00, 1);
        send5(5'b10000, 2'b00, 1);
        send5(5'b10000, 2'b01, 1);
        send5(5'b10000, 2'b10, 1);
        send5(5'b10000, 2'b11, 1);
        send5(5'b11111, 2'b10, 1);
        send5(5'b00000, 2'b11, 1);
        for (int i = 0; i < 40; i++) begin
            send5(5'($urandom), 2'($urandom_range(0, 3)), 1);
        end
        drain5();

        // Asynchronous reset with two beats in flight
        @(negedge clock);
        b16.out_ready = 1'b0;
        send16(16'hFFFF, 2'b00, 0);
        send16(16'h0F0F, 2'b10, 0);
        @(negedge clock);
        b16.in_valid = 1'b0;
        #1;
        chk("pre_reset_out_valid", b16.out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out_valid", b16.out_valid, 0);
        chk("async_rst_out_result", b16.out_result, 0);
        chk("async_rst_out_op", b16.out_op, 0);
        q16.delete();
        xfer16 = 0;
`ifdef REDUCE_STATS_EN
        chk("async_rst_count", b16.out_count, 0);
`endif
        @(negedge clock);
        #3 reset = 1'b1;
        b16.out_ready = 1'b1;
        send16(16'hFFFF, 2'b00, 1);
        drain16();
        chk("post_reset_xfers", xfer16, 1);

        // Ten transfers after a fresh reset
        @(negedge clock);
        #3 reset = 1'b0;
        xfer16 = 0;
        @(negedge clock);
        #3 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send16(rand_word(), 2'($urandom_range(0, 3)), 1);
        end
        drain16();
        chk("ten_xfers_seen", xfer16, 10);
`ifdef REDUCE_STATS_EN
        chk("out_count_ten", b16.out_count, 10);
        @(negedge clock);
        #3 reset = 1'b0;
        #1;
        chk("out_count_reset", b16.out_count, 0);
        @(negedge clock);
        #3 reset = 1'b1;
`endif

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
